vga_capture: RTL and testbench

- Receiving end of the VGA pixel interface: samples hsync/vsync and RGB565 pixel data driven on the same pixel clock.
- Recovers the active-video window from sync edges and porch counts.
- Writes one full frame into video memory as a linear pixel stream, one capture per `start` request.
- Sits between an on-chip VGA source (or test pattern path) and the video-memory write port. Used for frame grab and loopback verification of the display path.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_capture_sync_edge_detect.sv | 26 ++
 rtl/vga_capture.sv | 148 ++++++++++++++
 tb/tb_vga_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and capture state encoding.
// Consumed by the frame-capture block and the display timing generator.
package vga_timing_pkg;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;

    localparam int H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
    localparam int H_ACT_BEGIN = H_SYNC_DEF + H_BP_DEF;
    localparam int H_ACT_END   = H_ACT_BEGIN + H_ACTIVE_DEF;
    localparam int V_ACT_BEGIN = V_SYNC_DEF + V_BP_DEF;
    localparam int V_ACT_END   = V_ACT_BEGIN + V_ACTIVE_DEF;

    localparam int HCNT_BITS = 12;
    localparam int VCNT_BITS = 11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/vga_capture_sync_edge_detect.sv
// Registers one active-low sync input and flags its 1-to-0 transitions
// by comparing the registered level with the previous registered sample.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    output logic level,
    output logic fall
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= sync_in;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/vga_capture.sv
// Frame grabber on the VGA receive side: recovers the active window from the
// sync edges and writes one full RGB565 frame to video memory per start.
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC_A              = H_SYNC_DEF,
    parameter int H_BACK_PORCH_B        = H_BP_DEF,
    parameter int H_ACTIVE_VIDEO_TIME_C = H_ACTIVE_DEF,
    parameter int H_FRONT_PORCH_D       = H_FP_DEF,
    parameter int V_SYNC_O              = V_SYNC_DEF,
    parameter int V_BACK_PORCH_P        = V_BP_DEF,
    parameter int V_ACTIVE_VIDEO_TIME_Q = V_ACTIVE_DEF,
    parameter int V_FRONT_PORCH_R       = V_FP_DEF,
    parameter int VM_ADDR_BITS          = 23
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [4:0]            red,
    input  logic [5:0]            green,
    input  logic [4:0]            blue,
    output logic                  wr_en,
    output logic [VM_ADDR_BITS:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);

    localparam int ADDR_W   = VM_ADDR_BITS + 1;
    localparam int HPOS_W   = HCNT_BITS + 1;
    localparam int VPOS_W   = VCNT_BITS + 1;
    localparam int LINE_LEN = H_SYNC_A + H_BACK_PORCH_B + H_ACTIVE_VIDEO_TIME_C + H_FRONT_PORCH_D;

    localparam logic [HCNT_BITS-1:0] LINE_LAST   = HCNT_BITS'(LINE_LEN - 1);
    localparam logic [HCNT_BITS-1:0] HCNT_MAX    = '1;
    localparam logic [HPOS_W-1:0]    H_WIN_BEGIN = HPOS_W'(H_SYNC_A + H_BACK_PORCH_B);
    localparam logic [HPOS_W-1:0]    H_WIN_END   = HPOS_W'(H_SYNC_A + H_BACK_PORCH_B + H_ACTIVE_VIDEO_TIME_C);
    localparam logic [VPOS_W-1:0]    V_WIN_BEGIN = VPOS_W'(V_SYNC_O + V_BACK_PORCH_P);
    localparam logic [VPOS_W-1:0]    V_WIN_END   = VPOS_W'(V_SYNC_O + V_BACK_PORCH_P + V_ACTIVE_VIDEO_TIME_Q);
    localparam logic [ADDR_W-1:0]    LAST_ADDR   = ADDR_W'(H_ACTIVE_VIDEO_TIME_C * V_ACTIVE_VIDEO_TIME_Q - 1);

    logic                 hs_lvl, hfall, vs_lvl, vfall;
    logic [15:0]          rgb_q;
    logic [HCNT_BITS-1:0] hcnt;
    logic [VCNT_BITS-1:0] vcnt;
    logic [HPOS_W-1:0]    h_pos;
    logic [VPOS_W-1:0]    v_pos;
    logic                 pix_active, line_err, timing_err, hfall_exempt;
    logic [ADDR_W-1:0]    addr_cnt;
    cap_state_e           state;

    sync_edge_detect u_hsync (.clock(clock), .reset(reset), .sync_in(hsync), .level(hs_lvl), .fall(hfall));
    sync_edge_detect u_vsync (.clock(clock), .reset(reset), .sync_in(vsync), .level(vs_lvl), .fall(vfall));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            rgb_q <= {red, green, blue};
            if (hfall)
                hcnt <= '0;
            else if (hcnt != HCNT_MAX)
                hcnt <= hcnt + 1'b1;
            if (vfall)
                vcnt <= '0;
            else if (hfall)
                vcnt <= vcnt + 1'b1;
        end
    end

    // hcnt/vcnt trail the stage-1 pixel by one clock; h_pos/v_pos are that pixel's coordinates.
    always_comb begin
        h_pos      = hfall ? '0 : {1'b0, hcnt} + 1'b1;
        v_pos      = vfall ? '0 : (hfall ? {1'b0, vcnt} + 1'b1 : {1'b0, vcnt});
        pix_active = (h_pos >= H_WIN_BEGIN) && (h_pos < H_WIN_END) &&
                     (v_pos >= V_WIN_BEGIN) && (v_pos < V_WIN_END) &&
                     hs_lvl && vs_lvl;
        line_err   = hfall && !hfall_exempt && (hcnt != LINE_LAST);
        timing_err = line_err || (hcnt == HCNT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
            addr_cnt     <= '0;
            hfall_exempt <= 1'b0;
        end else begin
            // NOTE: single-cycle strobes default low here and are raised only in the cycles that need them.
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_ARM;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        addr_cnt     <= '0;
                        hfall_exempt <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (hfall)
                        hfall_exempt <= 1'b0;
                    if (timing_err) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else if (vfall) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (timing_err) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else if (pix_active) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= rgb_q;
                        addr_cnt <= addr_cnt + 1'b1;
                        if (addr_cnt == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 14x7 raster with an 8x4 active window.
module tb_vga_capture;

    localparam int A = 2, B = 2, C = 8, D = 2;
    localparam int O = 1, P = 1, Q = 4, R = 1;
    localparam int H_TOT = A + B + C + D;
    localparam int V_TOT = O + P + Q + R;
    localparam int HB = A + B;
    localparam int VB = O + P;
    localparam int LAST = C * Q - 1;

    logic        clock, reset, start, hsync, vsync;
    logic [15:0] pix;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic        wr_en, busy, frame_done, error;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;

    assign red   = pix[15:11];
    assign green = pix[10:5];
    assign blue  = pix[4:0];

    vga_capture #(
        .H_SYNC_A(A), .H_BACK_PORCH_B(B), .H_ACTIVE_VIDEO_TIME_C(C), .H_FRONT_PORCH_D(D),
        .V_SYNC_O(O), .V_BACK_PORCH_P(P), .V_ACTIVE_VIDEO_TIME_Q(Q), .V_FRONT_PORCH_R(R),
        .VM_ADDR_BITS(23)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;
    int frame_no = -1;
    int done_count = 0;
    int frame_writes [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        frame_no   = -1;
        done_count = 0;
        for (int i = 0; i < 8; i++) frame_writes[i] = 0;
    endtask

    // One raster frame; start pulses at column 5 of the given lines.
    task automatic drive_frame(input int start_line, input int start2_line,
                               input int short_line, input int n_lines);
        frame_no++;
        for (int l = 0; l < n_lines; l++) begin
            for (int p = 0; p < ((l == short_line) ? H_TOT - 1 : H_TOT); p++) begin
                @(negedge clock);
                hsync = (p < A) ? 1'b0 : 1'b1;
                vsync = (l < O) ? 1'b0 : 1'b1;
                if (l >= VB && l < VB + Q && p >= HB && p < HB + C)
                    pix = 16'((l - VB) * 256 + (p - HB));
                else
                    pix = 16'hDEAD;
                start = 1'b0;
                if (l == start_line && p == 5) begin
                    start   = 1'b1;
                    exp_idx = 0;
                end
                if (l == start2_line && p == 5)
                    start = 1'b1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_en"},      wr_en,      0);
        check({tag, ".wr_addr"},    wr_addr,    0);
        check({tag, ".wr_data"},    wr_data,    0);
        check({tag, ".busy"},       busy,       0);
        check({tag, ".frame_done"}, frame_done, 0);
        check({tag, ".error"},      error,      0);
    endtask

    // Scoreboard: every write must land at the next linear address with its pattern pixel.
    always @(posedge clock) begin
        #1;
        if (wr_en) begin
            check("wr_addr", wr_addr, exp_idx);
            check("wr_data", wr_data, 16'((exp_idx / C) * 256 + (exp_idx % C)));
            exp_idx++;
            if (frame_no >= 0 && frame_no < 8) frame_writes[frame_no]++;
        end
        if (frame_done) begin
            check("done_addr", wr_addr, LAST);
            check("done_with_wr_en", wr_en, 1);
            done_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string name;
        int    start_line;
        int    start2_line;
        int    short_line;
        int    exp_w1;
        int    exp_done;
        logic  exp_err;
    } vec_t;

    vec_t tbl [5];
    int   waited;

    initial begin
        tbl[0] = '{"pre_vfall",    6, -1, -1, 32, 1, 1'b0};
        tbl[1] = '{"mid_frame",    3, -1, -1, 32, 1, 1'b0};
        tbl[2] = '{"restart_busy", 6,  3, -1, 32, 1, 1'b0};
        tbl[3] = '{"short_line",   6, -1,  2,  8, 0, 1'b1};
        tbl[4] = '{"err_clear",    6, -1, -1, 32, 1, 1'b0};

        reset = 1'b0; start = 1'b0; hsync = 1'b1; vsync = 1'b1; pix = 16'h0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            clear_counts();
            drive_frame(tbl[i].start_line, -1, -1, V_TOT);
            drive_frame(-1, tbl[i].start2_line, tbl[i].short_line, V_TOT);
            drive_frame(-1, -1, -1, V_TOT);
            check($sformatf("%s.w0", tbl[i].name),   frame_writes[0], 0);
            check($sformatf("%s.w1", tbl[i].name),   frame_writes[1], tbl[i].exp_w1);
            check($sformatf("%s.w2", tbl[i].name),   frame_writes[2], 0);
            check($sformatf("%s.done", tbl[i].name), done_count,      tbl[i].exp_done);
            check($sformatf("%s.err", tbl[i].name),  error,           tbl[i].exp_err);
            check($sformatf("%s.busy", tbl[i].name), busy,            0);
        end

        // hsync lost during capture: error only once hcnt saturates.
        clear_counts();
        drive_frame(6, -1, -1, V_TOT);
        drive_frame(-1, -1, -1, 3);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clock);
            hsync = 1'b1; vsync = 1'b1; pix = 16'hDEAD;
        end
        check("hlost.busy_before", busy, 1);
        check("hlost.err_before",  error, 0);
        repeat (200) @(negedge clock);
        check("hlost.err_after",  error, 1);
        check("hlost.busy_after", busy, 0);
        check("hlost.writes",     frame_writes[1], C);
        check("hlost.done",       done_count, 0);

        // Asynchronous reset in the middle of a capture.
        clear_counts();
        drive_frame(6, -1, -1, V_TOT);
        fork
            drive_frame(-1, -1, -1, V_TOT);
            begin
                waited = 0;
                while (exp_idx < 10 && waited < 200) begin
                    @(negedge clock);
                    waited++;
                end
                check("rst.reached_ten_writes", (exp_idx >= 10), 1);
                #3 reset = 1'b1;
                #1 check_all_zero("rst_mid");
                repeat (2) @(negedge clock);
                reset = 1'b0;
            end
        join
        check("rst.writes_before", frame_writes[1], 10);
        drive_frame(-1, -1, -1, V_TOT);
        drive_frame(6, -1, -1, V_TOT);
        drive_frame(-1, -1, -1, V_TOT);
        check("rst.no_start_writes", frame_writes[2] + frame_writes[3], 0);
        check("rst.new_frame_writes", frame_writes[4], 32);
        check("rst.done",             done_count, 1);
        check("rst.err",              error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
